axi_issue_tracker: RTL
======================

# axi_issue_tracker

Parametrised read-issue tracker for the SpMV kernel's AXI master read path. It counts outstanding AR transactions and tags each one with a caller-supplied tag. Each returning single-beat R response is paired with its tag in a first-word-fall-through post FIFO. AR issue is gated by an outstanding limit, a post-issue cooldown and a credit check, so returned data can never overflow the post FIFO.

## Interface
Parameters:
- DATA_W, 64, AXI read data width
- TAG_W, 6, tag width (ServeNum+Seq = 3+3 by default)
- MAX_OUT, 2, max outstanding AR transactions (1..15)
- COLD, 3, busy cycles after each AR handshake (0 = none)
- POST_DEPTH, 8, post FIFO entries (power of 2, ≥ MAX_OUT)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- m_axi_arvalid  in  1  AR valid, observed
- m_axi_arready  in  1  AR ready, observed
- req_tag  in  TAG_W  tag, captured on AR handshake
- m_axi_rvalid  in  1  R valid
- m_axi_rready  out  1  R ready, driven by this block
- m_axi_rdata  in  DATA_W  R data
- m_axi_rresp  in  2  R response
- issue_busy  out  1  upstream must not raise arvalid
- issue_idle  out  1  nothing in flight, free to issue
- outstanding  out  $clog2(MAX_OUT+1)  AR accepted, R not yet accepted
- post_rd  in  1  pop post FIFO
- post_data  out  DATA_W+TAG_W  {rdata, tag}, valid while ~post_empty
- post_empty / post_full  out  1  post FIFO status
- post_count  out  $clog2(POST_DEPTH+1)  post FIFO occupancy
- ovf_err  out  1  sticky flag: AR accepted while outstanding==MAX_OUT
- rresp_err  out  1  sticky flag: non-OKAY rresp seen
- err_tag  out  TAG_W  tag of first non-OKAY response
- err_clr  in  1  clears rresp_err, err_tag and ovf_err

## Operation
- ar_hs = arvalid&arready; r_hs = rvalid&rready.
- outstanding: +1 on ar_hs only; −1 on r_hs only; unchanged when both occur. Saturates at MAX_OUT; on an ar_hs at MAX_OUT it holds and sets ovf_err.
- Tag FIFO, depth MAX_OUT: push req_tag on ar_hs; pop on r_hs. On an overflow ar_hs the tag is dropped.
- Cooldown counter: loads COLD on ar_hs; otherwise decrements to 0.
- credit_ok = outstanding + post_count < POST_DEPTH.
- issue_busy = (outstanding==MAX_OUT) | cold!=0 | ~arready | ~credit_ok.
- issue_idle = outstanding==0 & cold==0 & arready.
- m_axi_rready = outstanding!=0 & ~post_full. Stray R beats with nothing outstanding are never accepted.
- Post FIFO: push {rdata, popped tag} on r_hs; pop on post_rd & ~post_empty. post_rd while empty is ignored. Push and pop in the same cycle leave post_count unchanged.

## Timing
- Reset asynchronous; these clear immediately: outstanding, cold, both FIFO pointers, post_count, ovf_err, rresp_err, err_tag, post_data(0). After reset post_empty=1 and post_full=0.
- Reset mid-burst discards all tags and data. In-flight R beats after reset are not accepted (outstanding==0).
- issue_busy and issue_idle are combinational from registered state plus arready.
- R handshake to post_data visible: 1 cycle (registered write, FWFT read).
- Cooldown: after ar_hs in cycle N, cold!=0 during N+1..N+COLD; busy drops in N+COLD+1 if other terms allow.
- Tag FIFO read is combinational at the head, so tag and data pair in the same cycle.
- Pointers wrap modulo depth; full/empty use an extra wrap bit.

## Configuration
- ISSUE_RRESP_CHK_EN defined: on r_hs with rresp!=2'b00, rresp_err is set, and err_tag latches the tag if rresp_err was 0. err_clr has priority over a same-cycle set.
- Undefined: m_axi_rresp is ignored; rresp_err=0 and err_tag=0 constantly. err_clr clears only ovf_err.

## Test plan
- Reset with arready=1 → issue_idle=1, issue_busy=0, outstanding=0, post_empty=1. Assert rstn low mid-traffic → all status is back to the reset values in the same cycle.
- Issue AR tags 0x05 then 0x12 (MAX_OUT=2) → outstanding=2 and busy=1. Return 0xAA, 0xBB → post_data reads {0xAA,0x05} then {0xBB,0x12}.
- AR at cycle 10 with COLD=3 → busy cycles 11–13, busy=0 at cycle 14 (outstanding<MAX_OUT).
- Simultaneous ar_hs and r_hs → outstanding unchanged, tag order preserved. Fill post FIFO to 7 with 1 outstanding and no pops → busy=1 (credit), rready is held high and the 8th beat lands, giving post_full=1 and rready=0.
- Force ar_hs at outstanding=2 → ovf_err=1; err_clr → 0.
- With ISSUE_RRESP_CHK_EN: responses with tags 0x03 (SLVERR) then 0x04 (DECERR) → rresp_err=1, err_tag=0x03. Without the macro → rresp_err stays 0.

Source files
------------

// File: rtl/axi_issue_tracker_if.sv
// rtl/axi_issue_tracker_if.sv - AXI read-path signals observed and driven by the issue tracker
interface axi_issue_tracker_if #(
  parameter int DATA_W = 64
);
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic              m_axi_rvalid;
  logic              m_axi_rready;
  logic [DATA_W-1:0] m_axi_rdata;
  logic [1:0]        m_axi_rresp;

  modport master (
    output m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp,
    input  m_axi_rready
  );

  modport slave (
    input  m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp,
    output m_axi_rready
  );
endinterface

// File: rtl/axi_issue_tracker.sv
// rtl/axi_issue_tracker.sv - outstanding-AR tracker pairing R beats with tags in a FWFT post FIFO
// Optional rresp error capture enabled by defining ISSUE_RRESP_CHK_EN.
module axi_issue_tracker #(
  parameter  int DATA_W     = 64,
  parameter  int TAG_W      = 6,
  parameter  int MAX_OUT    = 2,
  parameter  int COLD       = 3,
  parameter  int POST_DEPTH = 8,
  localparam int OUT_W      = $clog2(MAX_OUT + 1),
  localparam int CNT_W      = $clog2(POST_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rstn,
  axi_issue_tracker_if.slave       axi,
  input  logic [TAG_W-1:0]         req_tag,
  output logic                     issue_busy,
  output logic                     issue_idle,
  output logic [OUT_W-1:0]         outstanding,
  input  logic                     post_rd,
  output logic [DATA_W+TAG_W-1:0]  post_data,
  output logic                     post_empty,
  output logic                     post_full,
  output logic [CNT_W-1:0]         post_count,
  output logic                     ovf_err,
  output logic                     rresp_err,
  output logic [TAG_W-1:0]         err_tag,
  input  logic                     err_clr
);

  localparam int TI_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW   = (COLD > 0) ? $clog2(COLD + 1) : 1;
  localparam int PAW  = $clog2(POST_DEPTH);
  localparam int PW   = DATA_W + TAG_W;

  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0]    cold_q, cold_d;
  logic [TI_W-1:0]  tag_wr_q, tag_rd_q;
  logic [TAG_W-1:0] tag_mem_q [MAX_OUT];
  logic [PAW:0]     post_wr_q, post_rd_q;
  logic [PW-1:0]    post_mem_q [POST_DEPTH];
  logic             ovf_err_q, ovf_err_d;

  logic ar_hs, r_hs, out_full, tag_push, ovf, post_pop, credit_ok;
  logic [TAG_W-1:0] head_tag;

  assign ar_hs    = axi.m_axi_arvalid & axi.m_axi_arready;
  assign r_hs     = axi.m_axi_rvalid & axi.m_axi_rready;
  assign out_full = (outstanding_q == OUT_W'(MAX_OUT));
  // A full tag FIFO can still take a tag when a response frees the head slot this cycle.
  assign tag_push = ar_hs & (~out_full | r_hs);
  assign ovf      = ar_hs & out_full & ~r_hs;
  assign head_tag = tag_mem_q[tag_rd_q];

  function automatic logic [TI_W-1:0] tag_next(input logic [TI_W-1:0] p);
    return (p == TI_W'(MAX_OUT - 1)) ? '0 : p + TI_W'(1);
  endfunction

  always_comb begin
    outstanding_d = outstanding_q;
    if (tag_push && !r_hs)
      outstanding_d = outstanding_q + OUT_W'(1);
    else if (r_hs && !ar_hs)
      outstanding_d = outstanding_q - OUT_W'(1);
  end

  always_comb begin
    cold_d = cold_q;
    if (ar_hs)
      cold_d = CW'(COLD);
    else if (cold_q != '0)
      cold_d = cold_q - CW'(1);
  end

  always_comb begin
    ovf_err_d = ovf_err_q;
    if (err_clr)
      ovf_err_d = 1'b0;
    else if (ovf)
      ovf_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outstanding_q <= '0;
      cold_q        <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      post_wr_q     <= '0;
      post_rd_q     <= '0;
      ovf_err_q     <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      cold_q        <= cold_d;
      ovf_err_q     <= ovf_err_d;
      if (tag_push) tag_wr_q <= tag_next(tag_wr_q);
      if (r_hs)     tag_rd_q <= tag_next(tag_rd_q);
      if (r_hs)     post_wr_q <= post_wr_q + (PAW+1)'(1);
      if (post_pop) post_rd_q <= post_rd_q + (PAW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (tag_push) tag_mem_q[tag_wr_q] <= req_tag;
    if (r_hs)     post_mem_q[post_wr_q[PAW-1:0]] <= {axi.m_axi_rdata, head_tag};
  end

  assign post_empty = (post_wr_q == post_rd_q);
  assign post_full  = (post_wr_q[PAW] != post_rd_q[PAW]) &&
                      (post_wr_q[PAW-1:0] == post_rd_q[PAW-1:0]);
  assign post_count = CNT_W'(post_wr_q - post_rd_q);
  assign post_pop   = post_rd & ~post_empty;
  // Gate the head with empty so post_data reads zero out of reset.
  assign post_data  = post_empty ? '0 : post_mem_q[post_rd_q[PAW-1:0]];

  assign credit_ok        = (int'(outstanding_q) + int'(post_count)) < POST_DEPTH;
  assign issue_busy       = out_full | (cold_q != '0) | ~axi.m_axi_arready | ~credit_ok;
  assign issue_idle       = (outstanding_q == '0) & (cold_q == '0) & axi.m_axi_arready;
  assign axi.m_axi_rready = (outstanding_q != '0) & ~post_full;
  assign outstanding      = outstanding_q;
  assign ovf_err          = ovf_err_q;

`ifdef ISSUE_RRESP_CHK_EN
  logic             rresp_err_q, rresp_err_d;
  logic [TAG_W-1:0] err_tag_q, err_tag_d;
  logic             bad_resp;

  assign bad_resp = r_hs & (axi.m_axi_rresp != 2'b00);

  always_comb begin
    rresp_err_d = rresp_err_q;
    err_tag_d   = err_tag_q;
    if (err_clr) begin
      rresp_err_d = 1'b0;
      err_tag_d   = '0;
    end else if (bad_resp) begin
      rresp_err_d = 1'b1;
      if (!rresp_err_q) err_tag_d = head_tag;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rresp_err_q <= 1'b0;
      err_tag_q   <= '0;
    end else begin
      rresp_err_q <= rresp_err_d;
      err_tag_q   <= err_tag_d;
    end
  end

  assign rresp_err = rresp_err_q;
  assign err_tag   = err_tag_q;
`else
  logic unused_rresp;
  assign unused_rresp = ^axi.m_axi_rresp;
  assign rresp_err    = 1'b0;
  assign err_tag      = '0;
`endif

endmodule
